// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types for the 5-stage MIPS core.
//   sb_entry_t : one in-flight register writer {valid, wreg, is_load}
//   hu_state_t : hazard unit FSM states {BOOT, RUN, HOLD}
//   REG_ZERO   : hard-wired zero register number
//   sb_match   : true when the ID instruction reads the register held in a slot
package pipe_ctrl_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] wreg;
    logic       is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD
  } hu_state_t;

  // Register 0 is excluded explicitly even though valid slots never hold it.
  function automatic logic sb_match(input sb_entry_t  s,
                                    input logic       uses_rs,
                                    input logic [4:0] rs,
                                    input logic       uses_rt,
                                    input logic [4:0] rt);
    return s.valid && (s.wreg != REG_ZERO) &&
           ((uses_rs && (rs == s.wreg)) || (uses_rt && (rt == s.wreg)));
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-slot shift register of in-flight register writers (EX and MEM stages).
// Ports:
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   hold       : keep both slots unchanged (pipe frozen)
//   bubble     : advance, but insert an invalid entry into EX
//   id_entry   : writer descriptor of the instruction leaving ID
//   ex_sb      : writer currently in EX
//   mem_sb     : writer currently in MEM
module hazard_scoreboard
  import pipe_ctrl_pkg::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      hold,
  input  logic      bubble,
  input  sb_entry_t id_entry,
  output sb_entry_t ex_sb,
  output sb_entry_t mem_sb
);

  // hold wins over bubble: a frozen pipe moves nothing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_sb  <= '0;
      mem_sb <= '0;
    end else if (!hold) begin
      mem_sb <= ex_sb;
      ex_sb  <= bubble ? sb_entry_t'('0) : id_entry;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage MIPS core.
// Detects load-use and branch-operand hazards from a 2-entry writer
// scoreboard, flushes IF/ID on taken control transfers and freezes the
// pipe on memory wait.
// Ports:
//   clk, reset                 : rising-edge clock, async active-high reset
//   id_rs/id_rt, id_uses_rs/rt : source registers of the ID instruction
//   id_is_branch               : ID instruction compares/reads operands in ID
//   id_reg_write, id_write_reg : ID instruction destination
//   id_mem_read                : ID instruction is a load
//   id_pc_src                  : taken branch / jump decided in ID
//   mem_busy                   : memory wait, freezes the whole pipe
//   pc_stall, if_id_stall      : hold PC / IF/ID
//   if_id_flush                : turn IF/ID into a nop
//   id_ex_bubble               : load control-zero into ID/EX
//   ex_mem_hold                : hold EX/MEM and MEM/WB
//   stall_count, flush_count   : saturating event counters
module hazard_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic             id_reg_write,
  input  logic [4:0]       id_write_reg,
  input  logic             id_mem_read,
  input  logic             id_pc_src,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  hu_state_t state;
  sb_entry_t ex_sb;
  sb_entry_t mem_sb;
  sb_entry_t id_entry;

  logic match_ex;
  logic match_mem;
  logic hz;
  logic frozen;
  logic run_active;
  logic run_stall;
  logic run_flush;
  logic sb_bubble;

  always_comb begin
    id_entry         = '0;
    id_entry.valid   = id_reg_write && (id_write_reg != REG_ZERO);
    id_entry.wreg    = id_write_reg;
    id_entry.is_load = id_mem_read;
  end

  assign match_ex  = sb_match(ex_sb,  id_uses_rs, id_rs, id_uses_rt, id_rt);
  assign match_mem = sb_match(mem_sb, id_uses_rs, id_rs, id_uses_rt, id_rt);

  // Branches resolve in ID: any EX writer is too late to forward, a load in
  // MEM is too late as well; ALU results in MEM forward to ID.
  assign hz = (match_ex && (ex_sb.is_load || id_is_branch)) ||
              (id_is_branch && match_mem && mem_sb.is_load);

  // mem_busy acts in the very cycle it rises while in RUN.
  assign frozen     = (state == HOLD) || ((state == RUN) && mem_busy);
  assign run_active = (state == RUN) && !mem_busy;
  assign run_stall  = run_active && hz;
  assign run_flush  = run_active && !hz && id_pc_src;
  assign sb_bubble  = (state == BOOT) || run_stall;

  hazard_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .hold     (frozen),
    .bubble   (sb_bubble),
    .id_entry (id_entry),
    .ex_sb    (ex_sb),
    .mem_sb   (mem_sb)
  );

  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    ex_mem_hold  = 1'b0;
    if (state == BOOT) begin
      pc_stall     = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (frozen) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      ex_mem_hold = 1'b1;
    end else if (run_stall) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (run_flush) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (mem_busy) state <= HOLD;
        HOLD:    if (!mem_busy) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (run_stall && (stall_count != '1))
        stall_count <= stall_count + CNT_W'(1);
      if (run_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
